vga_draw_bars: RTL and testbench
================================

// Module: vga_draw_bars
// PURPOSE
//  Downstream overlay stage after vga_top_draw_pict. Draws one horizontal bar per voltmeter channel over the
//  incoming picture stream. Channel values arrive on a valid/ready write port into shadow registers.
//  Shadow values are committed to the active set once per frame, at the vsync rising edge, so bars never tear.
//  Output feeds the next VGA stage or the pin driver.
// PARAMETERS
//  CHANNELS    13      number of bars/channels (1..16)
//  VAL_W       12      channel value width, bits (>=9)
//  BAR_X0      64      left x of every bar, px
//  BAR_Y0      40      top y of bar 0, px
//  PITCH_LOG2  5       vertical bar pitch = 2**PITCH_LOG2 px (32)
//  BAR_H       24      bar height px; must be < 2**PITCH_LOG2
//  THRESH      3300    value > THRESH drawn in OVER_COLOR
//  BAR_COLOR   12'h0F0 normal bar colour
//  OVER_COLOR  12'hF00 over-threshold bar colour
// PORTS
//  clk        in   1                 pixel clock
//  rst        in   1                 asynchronous, active-low reset
//  vga_in     in   `VGA_BUS_SIZE     timing+rgb bus from picture stage (hcount,vcount,hsync,vsync,hblnk,vblnk,rgb)
//  vga_out    out  `VGA_BUS_SIZE     same bus, delayed 2 clk, rgb overlaid
//  wr_valid   in   1                 channel write request
//  wr_ready   out  1                 write accepted when wr_valid&&wr_ready at posedge clk
//  wr_ch      in   4                 channel index
//  wr_data    in   VAL_W             channel value
//  frame_tick out  1                 1-clk pulse on the commit cycle
// BEHAVIOUR
//  Reset (rst=0, async): vga_out all 0, shadow[] and active[] = 0, wr_ready=0, frame_tick=0, vsync_d=0.
//   First clk after release: wr_ready=1.
//  Write port:
//   - Accept: shadow[wr_ch] <= wr_data.
//   - wr_ch >= CHANNELS: accepted and dropped, no register changes.
//   - wr_ready low only during the commit cycle. wr_valid with wr_ready=0 is held by the master and retried.
//   - Shadow data is not visible on screen until the next commit.
//  Commit:
//   - vsync_d = vsync registered each clk. Commit cycle = vsync & ~vsync_d seen at stage-0 input.
//   - On commit: active[i] <= shadow[i] for all i; frame_tick=1 for exactly that clk.
//   - A write to shadow in the same clk is impossible (wr_ready=0). A write in the cycle before commit is included.
//  Pixel pipeline, latency 2 clk. All bus timing fields pass through two register stages unchanged.
//   Stage 1:
//     - dy = vcount - BAR_Y0; ch = dy >> PITCH_LOG2; row = dy[PITCH_LOG2-1:0].
//     - in_row = (vcount >= BAR_Y0) && (ch < CHANNELS) && (row < BAR_H).
//     - dx = hcount - BAR_X0; in_col0 = hcount >= BAR_X0.
//   Stage 2:
//     - len = active[ch] >> (VAL_W-9), range 0..511.
//     - hit = in_row && in_col0 && (dx < len) && !hblnk && !vblnk.
//     - rgb_out = hit ? (active[ch] > THRESH ? OVER_COLOR : BAR_COLOR) : rgb_in (delayed 2).
//  Widths:
//   - Subtractions are done at hcount/vcount width+1; negative results (MSB set) mean not in region.
//   - Value 0 draws nothing. Full scale (4095) draws 511 px: x BAR_X0..BAR_X0+510.
//  Boundaries:
//   - Last bar row = BAR_Y0 + (CHANNELS-1)*2**PITCH_LOG2 + BAR_H - 1.
//   - Pixels in the gap rows (row >= BAR_H) pass through.
//   - Reset mid-frame: output 0 immediately. Overlay resumes with all bars empty until writes and a commit occur.
// TESTING
//  1. Reset, no writes, 800x600 frame -> vga_out rgb == vga_in rgb delayed 2 clk, every pixel; wr_ready=1 after release.
//  2. Write ch0=4095, then vsync edge -> frame_tick 1 clk; next frame y40..63 x64..574 = 12'hF00, x575 passes through.
//  3. Write ch12=2048 mid-frame -> current frame unchanged; next frame y424..447 x64..319 = 12'h0F0.
//  4. wr_valid held across commit cycle -> wr_ready=0 that clk only; write lands next clk and shows one frame later.
//  5. wr_ch=15, data=4095 -> no bar anywhere after commit; y64..71 gap rows always pass through.
//  6. Assert rst mid-line -> vga_out=0 asynchronously; after release, bars empty until a write and a commit.

Source files
------------

// File: rtl/vga_draw_bars.sv
// vga_draw_bars: overlays one horizontal bar per voltmeter channel on a VGA picture stream.
//
// Channel values are written through a valid/ready port into shadow registers. At every
// vsync rising edge the shadow set is copied into the active set, so a bar never changes
// mid-frame. The pixel path is two register stages deep; all timing fields pass unchanged.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous active-low reset
//   vga_in     in   {hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}
//   vga_out    out  same bus, 2 clk later, rgb overlaid with bars
//   wr_valid   in   channel write request
//   wr_ready   out  write accepted on posedge clk when wr_valid && wr_ready
//   wr_ch      in   channel index (indices >= Channels are accepted and dropped)
//   wr_data    in   channel value
//   frame_tick out  one-clk pulse on the commit cycle

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module vga_draw_bars #(
  parameter int unsigned Channels  = 13,
  parameter int unsigned ValW      = 12,
  parameter int unsigned BarX0     = 64,
  parameter int unsigned BarY0     = 40,
  parameter int unsigned PitchLog2 = 5,
  parameter int unsigned BarH      = 24,
  parameter int unsigned Thresh    = 3300,
  parameter logic [11:0] BarColor  = 12'h0F0,
  parameter logic [11:0] OverColor = 12'hF00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`VGA_BUS_SIZE-1:0]  vga_in,
  output logic [`VGA_BUS_SIZE-1:0]  vga_out,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [3:0]                wr_ch,
  input  logic [ValW-1:0]           wr_data,
  output logic                      frame_tick
);

  localparam int unsigned BusW     = `VGA_BUS_SIZE;
  localparam int unsigned HcntLsb  = 27;
  localparam int unsigned VcntLsb  = 16;
  localparam int unsigned VsyncBit = 14;
  localparam int unsigned HblnkBit = 13;
  localparam int unsigned VblnkBit = 12;
  localparam int unsigned ChW      = 11 - PitchLog2;

  logic [10:0] hcount_in, vcount_in;
  assign hcount_in = vga_in[HcntLsb +: 11];
  assign vcount_in = vga_in[VcntLsb +: 11];

  // ---------------------------------------------------------------------------
  // Write port and per-frame commit
  // ---------------------------------------------------------------------------
  logic vsync_q;
  logic rdy_q;  // low in reset, high from the first clk after release
  logic commit;
  logic wr_fire;

  assign commit     = vga_in[VsyncBit] & ~vsync_q & rdy_q;
  assign wr_ready   = rdy_q & ~commit;
  assign frame_tick = commit;
  assign wr_fire    = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      vsync_q <= vga_in[VsyncBit];
      rdy_q   <= 1'b1;
    end
  end

  logic [ValW-1:0] shadow_q [Channels];
  logic [ValW-1:0] active_q [Channels];

  // wr_ready is low on the commit cycle, so a write and a commit never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Channels; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < Channels; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_fire) begin
        for (int i = 0; i < Channels; i++) begin
          if (wr_ch == 4'(i)) shadow_q[i] <= wr_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: region decode
  // ---------------------------------------------------------------------------
  logic [11:0]    dy, dx;
  logic [ChW-1:0] ch_full;
  logic           in_row_d, in_col_d;

  always_comb begin
    // One extra bit so that a position left of / above the bar area shows up as negative.
    dy       = {1'b0, vcount_in} - 12'(BarY0);
    dx       = {1'b0, hcount_in} - 12'(BarX0);
    ch_full  = dy[10:PitchLog2];
    in_row_d = ~dy[11] && (ch_full < ChW'(Channels)) &&
               (dy[PitchLog2-1:0] < PitchLog2'(BarH));
    in_col_d = ~dx[11];
  end

  logic [BusW-1:0] bus1_q;
  logic            in_row1_q, in_col1_q;
  logic [10:0]     dx1_q;
  logic [3:0]      ch1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus1_q    <= '0;
      in_row1_q <= 1'b0;
      in_col1_q <= 1'b0;
      dx1_q     <= '0;
      ch1_q     <= '0;
    end else begin
      bus1_q    <= vga_in;
      in_row1_q <= in_row_d;
      in_col1_q <= in_col_d;
      dx1_q     <= dx[10:0];
      ch1_q     <= ch_full[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: bar length compare and colour select
  // ---------------------------------------------------------------------------
  logic [ValW-1:0] active_sel;
  logic [8:0]      len;
  logic            hit, over;
  logic [11:0]     rgb_d;

  always_comb begin
    active_sel = '0;
    for (int i = 0; i < Channels; i++) begin
      if (ch1_q == 4'(i)) active_sel = active_q[i];
    end
    // Top 9 bits of the value give the bar length in pixels (0..511).
    len   = active_sel[ValW-1 -: 9];
    over  = active_sel > ValW'(Thresh);
    hit   = in_row1_q & in_col1_q & (dx1_q < {2'b00, len}) &
            ~bus1_q[HblnkBit] & ~bus1_q[VblnkBit];
    rgb_d = hit ? (over ? OverColor : BarColor) : bus1_q[11:0];
  end

  logic [BusW-1:0] out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= {bus1_q[BusW-1:12], rgb_d};
    end
  end

  assign vga_out = out_q;

endmodule

// File: tb/tb_vga_draw_bars.sv
// Testbench for vga_draw_bars: scoreboard of expected output pixels, popped by a monitor
// two clocks after each pixel is driven. Frames are sparse: only selected lines/columns
// around the bar edges are driven, followed by a vsync pulse.
module tb_vga_draw_bars;

  localparam int BusW  = 38;
  localparam int VsBit = 14;
  localparam int HbBit = 13;
  localparam int VbBit = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [BusW-1:0] vga_in = '0;
  logic [BusW-1:0] vga_out;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [3:0]      wr_ch = '0;
  logic [11:0]     wr_data = '0;
  logic            frame_tick;

  vga_draw_bars dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vga_in),
    .vga_out    (vga_out),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [BusW-1:0] exp_q[$];
  logic [BusW-1:0] mon_e;
  logic [11:0]     m_shadow[16];
  logic [11:0]     m_active[16];
  logic            m_vs_q = 1'b0;
  logic            m_rdy  = 1'b0;
  logic            drv_valid = 1'b0;
  logic            v1 = 1'b0;
  logic            v2 = 1'b0;
  logic            want_wr = 1'b0;
  logic [3:0]      want_ch = '0;
  logic [11:0]     want_data = '0;

  int hlist[23] = '{0, 1, 62, 63, 64, 65, 69, 70, 71, 187, 188, 189, 318, 319, 320, 321,
                    500, 573, 574, 575, 576, 577, 799};
  int vlist[18] = '{0, 39, 40, 41, 63, 64, 71, 72, 200, 223, 224, 424, 447, 448, 455, 456,
                    520, 599};

  // Reference state: vsync register, ready-after-reset, and which driven pixels are in flight.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vs_q <= 1'b0;
      m_rdy  <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      m_vs_q <= vga_in[VsBit];
      m_rdy  <= 1'b1;
      v1     <= drv_valid;
      v2     <= v1;
    end
  end

  task automatic check(input string name, input logic [BusW-1:0] act, input logic [BusW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output slot that corresponds to a driven pixel is compared.
  always @(negedge clk) begin
    if (rst && v2) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pixel: got %h with no expected entry at %0t", vga_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", vga_out, mon_e);
      end
    end
  end

  function automatic logic [BusW-1:0] pack(input int h, input int v, input bit hs, input bit vs,
                                           input bit hb, input bit vb, input logic [11:0] rgb);
    return {11'(h), 11'(v), hs, vs, hb, vb, rgb};
  endfunction

  function automatic logic [11:0] pat(input int h, input int v);
    logic [10:0] hh, vv;
    hh = 11'(h);
    vv = 11'(v);
    return {hh[3:0], vv[3:0], 4'hA};
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb, input bit vb,
                                          input logic [11:0] rgb);
    int dy, ch, row, len;
    if (hb || vb || v < 40 || h < 64) return rgb;
    dy  = v - 40;
    ch  = dy / 32;
    row = dy % 32;
    if (ch >= 13 || row >= 24) return rgb;
    len = int'(m_active[ch]) / 8;
    if (h - 64 >= len) return rgb;
    return (m_active[ch] > 12'd3300) ? 12'hF00 : 12'h0F0;
  endfunction

  // One clock: drive bus + write port, check handshake outputs, queue the expected pixel.
  task automatic cycle(input bit push, input logic [BusW-1:0] bus, input bit hand,
                       input logic [11:0] hand_rgb);
    logic        commit, exp_ready;
    logic [11:0] e_rgb;
    @(negedge clk);
    vga_in    = bus;
    drv_valid = push;
    wr_valid  = want_wr;
    wr_ch     = want_ch;
    wr_data   = want_data;
    commit    = bus[VsBit] && !m_vs_q && m_rdy;
    if (commit) for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
    exp_ready = m_rdy && !commit;
    #1;
    check("wr_ready", BusW'(wr_ready), BusW'(exp_ready));
    check("frame_tick", BusW'(frame_tick), BusW'(commit));
    if (push) begin
      e_rgb = hand ? hand_rgb
                   : exp_rgb(int'(bus[37:27]), int'(bus[26:16]), bus[HbBit], bus[VbBit],
                             bus[11:0]);
      exp_q.push_back({bus[BusW-1:12], e_rgb});
    end
    if (want_wr && exp_ready) begin
      if (want_ch < 4'd13) m_shadow[want_ch] = want_data;
      want_wr = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, vga_in, 1'b0, 12'h0);
  endtask

  task automatic px(input int h, input int v, input logic [11:0] e);
    cycle(1'b1, pack(h, v, 1'b0, 1'b0, 1'b0, 1'b0, pat(h, v)), 1'b1, e);
  endtask

  task automatic scan_frame(input bit mid_wr);
    for (int li = 0; li < 18; li++) begin
      if (mid_wr && li == 6) want_wr = 1'b1;
      for (int hi = 0; hi < 23; hi++) begin
        cycle(1'b1, pack(hlist[hi], vlist[li], hlist[hi] == 799, 1'b0, hlist[hi] == 70, 1'b0,
                         pat(hlist[hi], vlist[li])), 1'b0, 12'h0);
      end
    end
  endtask

  task automatic vsync_pulse(input bit wr_at_commit);
    cycle(1'b1, pack(0, 601, 1'b0, 1'b0, 1'b0, 1'b1, pat(0, 601)), 1'b0, 12'h0);
    if (wr_at_commit) want_wr = 1'b1;
    cycle(1'b1, pack(0, 602, 1'b0, 1'b1, 1'b0, 1'b1, pat(0, 602)), 1'b0, 12'h0);
    cycle(1'b1, pack(0, 603, 1'b0, 1'b1, 1'b0, 1'b1, pat(0, 603)), 1'b0, 12'h0);
    cycle(1'b1, pack(0, 604, 1'b0, 1'b0, 1'b0, 1'b1, pat(0, 604)), 1'b0, 12'h0);
  endtask

  task automatic write(input logic [3:0] ch, input logic [11:0] data);
    want_ch   = ch;
    want_data = data;
    want_wr   = 1'b1;
    for (int k = 0; k < 10 && want_wr; k++) idle(1);
    if (want_wr) begin
      n_cmp++;
      n_err++;
      $display("FAIL write_accept: got no acceptance expected within 10 clk at %0t", $time);
      want_wr = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    exp_q.delete();
    drv_valid = 1'b0;
    want_wr   = 1'b0;
    wr_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_vga_out", vga_out, '0);
    check("rst_wr_ready", BusW'(wr_ready), '0);
    check("rst_frame_tick", BusW'(frame_tick), '0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_before_first_clk", BusW'(wr_ready), '0);
  endtask

  initial begin
    clear_model();
    vga_in = pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, pat(0, 0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    release_rst();

    // No writes: everything passes through.
    scan_frame(1'b0);
    vsync_pulse(1'b0);
    scan_frame(1'b0);

    // Full-scale ch0 appears only after the next commit.
    write(4'd0, 12'd4095);
    scan_frame(1'b0);
    px(64, 40, pat(64, 40));
    vsync_pulse(1'b0);
    scan_frame(1'b0);
    px(64, 40, 12'hF00);
    px(574, 40, 12'hF00);
    px(575, 40, pat(575, 40));
    px(63, 40, pat(63, 40));
    px(300, 63, 12'hF00);
    px(300, 64, pat(300, 64));

    // Mid-frame write to ch12 stays hidden until the following frame.
    want_ch   = 4'd12;
    want_data = 12'd2048;
    scan_frame(1'b1);
    px(64, 424, pat(64, 424));
    vsync_pulse(1'b0);
    scan_frame(1'b0);
    px(319, 424, 12'h0F0);
    px(320, 424, pat(320, 424));
    px(64, 447, 12'h0F0);
    px(64, 448, pat(64, 448));

    // Write held across the commit cycle: lands one clk later, shows one frame later.
    want_ch   = 4'd5;
    want_data = 12'd1000;
    vsync_pulse(1'b1);
    scan_frame(1'b0);
    px(100, 200, pat(100, 200));
    vsync_pulse(1'b0);
    scan_frame(1'b0);
    px(188, 200, 12'h0F0);
    px(189, 200, pat(189, 200));

    // Out-of-range channel is dropped; gap rows pass through.
    write(4'd15, 12'd4095);
    vsync_pulse(1'b0);
    scan_frame(1'b0);
    px(100, 64, pat(100, 64));
    px(100, 71, pat(100, 71));
    px(64, 456, pat(64, 456));
    px(574, 40, 12'hF00);

    // Reset in the middle of a bar line.
    px(64, 40, 12'hF00);
    px(65, 40, 12'hF00);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    idle(1);
    check("rst_hold_vga_out", vga_out, '0);
    release_rst();
    scan_frame(1'b0);
    px(64, 40, pat(64, 40));
    vsync_pulse(1'b0);
    scan_frame(1'b0);
    px(64, 40, pat(64, 40));
    write(4'd0, 12'd8);
    vsync_pulse(1'b0);
    px(64, 40, 12'h0F0);
    px(65, 40, pat(65, 40));

    idle(4);
    check("scoreboard_drained", BusW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
